// File: rtl/pcm_capture_if.sv
// Register-side view of the capture FIFO: control strobes from the CPU,
// head byte and status flags back to it.
interface pcm_capture_if #(
    parameter int FIFO_AW = 10
);
    logic               fifo_reset;
    logic               fifo_read;
    logic [7:0]         fifo_rddata;
    logic               fifo_empty;
    logic               fifo_almost_full;
    logic [FIFO_AW:0]   fifo_count;
    logic               overrun;

    modport master (
        output fifo_reset, fifo_read,
        input  fifo_rddata, fifo_empty, fifo_almost_full, fifo_count, overrun
    );

    modport slave (
        input  fifo_reset, fifo_read,
        output fifo_rddata, fifo_empty, fifo_almost_full, fifo_count, overrun
    );
endinterface

// File: rtl/pcm_capture.sv
// Audio capture path: decimates L/R samples with an 8-bit rate accumulator,
// packs whole frames into bytes and buffers them in a first-word-fall-through FIFO.
module pcm_capture #(
    parameter int FIFO_AW          = 10,
    parameter int ALMOST_FULL_FREE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_sample,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        enable,
    input  logic [7:0]  sample_rate,
    input  logic        mode_stereo,
    input  logic        mode_16bit,
    pcm_capture_if.slave rd
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        PUT_L_LO,
        PUT_L_HI,
        PUT_R_LO,
        PUT_R_HI
    } state_e;

    logic [7:0]         acc_q;
    logic               acc7_q;
    logic               tick_q;
    logic [15:0]        left_q;
    logic [15:0]        right_q;
    state_e             state_q, state_d;
    logic               stereo_q;
    logic               wide_q;
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overrun_q;
    logic [7:0]         mem [DEPTH];

    logic               capture;
    logic               accept;
    logic               drop;
    logic               pop;
    logic               wr_en;
    logic [7:0]         wr_byte;
    logic [FIFO_AW:0]   frame_bytes;
    logic [FIFO_AW:0]   free_space;

    // A capture fires when the accumulator's MSB toggled on the last tick.
    assign capture    = tick_q && (acc7_q != acc_q[7]);
    assign free_space = (FIFO_AW+1)'(DEPTH) - count_q;
    assign accept     = capture && (state_q == IDLE) && (free_space >= frame_bytes);
    assign drop       = capture && !accept;
    assign pop        = rd.fifo_read && (count_q != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        frame_bytes = (FIFO_AW+1)'(1);
        if (mode_16bit && mode_stereo)
            frame_bytes = (FIFO_AW+1)'(4);
        else if (mode_16bit || mode_stereo)
            frame_bytes = (FIFO_AW+1)'(2);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            acc7_q  <= 1'b0;
            tick_q  <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else if (rd.fifo_reset || !enable) begin
            acc_q   <= '0;
            acc7_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else if (next_sample) begin
            acc_q   <= acc_q + sample_rate;
            acc7_q  <= acc_q[7];
            left_q  <= left_in;
            right_q <= right_in;
            tick_q  <= 1'b1;
        end else begin
            tick_q  <= 1'b0;
        end
    end

    // Hold registers stay stable for the whole frame since ticks are >= 8 cycles apart.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_byte = 8'h00;
        case (state_q)
            IDLE: begin
                if (accept) state_d = PUT_L_LO;
            end
            PUT_L_LO: begin
                wr_en   = 1'b1;
                wr_byte = wide_q ? left_q[7:0] : left_q[15:8];
                state_d = wide_q ? PUT_L_HI : (stereo_q ? PUT_R_LO : IDLE);
            end
            PUT_L_HI: begin
                wr_en   = 1'b1;
                wr_byte = left_q[15:8];
                state_d = stereo_q ? PUT_R_LO : IDLE;
            end
            PUT_R_LO: begin
                wr_en   = 1'b1;
                wr_byte = wide_q ? right_q[7:0] : right_q[15:8];
                state_d = wide_q ? PUT_R_HI : IDLE;
            end
            PUT_R_HI: begin
                wr_en   = 1'b1;
                wr_byte = right_q[15:8];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rd.fifo_reset) begin
            state_d = IDLE;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stereo_q <= 1'b0;
            wide_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !rd.fifo_reset) begin
                stereo_q <= mode_stereo;
                wide_q   <= mode_16bit;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)
            count_d = count_q + (FIFO_AW+1)'(1);
        else if (!wr_en && pop)
            count_d = count_q - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else if (rd.fifo_reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            count_q <= count_d;
            if (drop)  overrun_q <= 1'b1;
        end
    end

    // NOTE: storage array has no reset; an empty FIFO masks its contents to 0x00.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_byte;
    end

    assign rd.fifo_rddata      = (count_q == '0) ? 8'h00 : mem[rd_ptr_q];
    assign rd.fifo_empty       = (count_q == '0);
    assign rd.fifo_almost_full = (DEPTH - int'(count_q)) < ALMOST_FULL_FREE;
    assign rd.fifo_count       = count_q;
    assign rd.overrun          = overrun_q;
endmodule

// File: tb/tb_pcm_capture.sv
// Self-checking bench for pcm_capture: directed boundary cases plus a random
// phase, all compared against a byte-queue model of the capture path.
module tb_pcm_capture;
    localparam int FIFO_AW = 10;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int AF_FREE = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        next_sample = 1'b0;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        enable = 1'b0;
    logic [7:0]  sample_rate = '0;
    logic        mode_stereo = 1'b0;
    logic        mode_16bit = 1'b0;

    pcm_capture_if #(.FIFO_AW(FIFO_AW)) rd ();

    pcm_capture #(.FIFO_AW(FIFO_AW), .ALMOST_FULL_FREE(AF_FREE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_sample (next_sample),
        .left_in     (left_in),
        .right_in    (right_in),
        .enable      (enable),
        .sample_rate (sample_rate),
        .mode_stereo (mode_stereo),
        .mode_16bit  (mode_16bit),
        .rd          (rd)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_acc    = 0;
    bit         m_ovr    = 1'b0;
    logic [7:0] m_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_ovr = 1'b0;
        m_q.delete();
    endtask

    task automatic push_channel(input logic [15:0] s);
        if (mode_16bit) begin
            m_q.push_back(s[7:0]);
            m_q.push_back(s[15:8]);
        end else begin
            m_q.push_back(s[15:8]);
        end
    endtask

    // Decimation by MSB crossing, whole-frame admission, byte order per mode.
    task automatic model_tick(input logic [15:0] l, input logic [15:0] r);
        int old_acc;
        int nbytes;
        if (!enable) begin
            m_acc = 0;
            return;
        end
        old_acc = m_acc;
        m_acc   = (m_acc + int'(sample_rate)) % 256;
        if ((old_acc >= 128) == (m_acc >= 128)) return;
        nbytes = (mode_16bit ? 2 : 1) * (mode_stereo ? 2 : 1);
        if (DEPTH - m_q.size() < nbytes) begin
            m_ovr = 1'b1;
            return;
        end
        push_channel(l);
        if (mode_stereo) push_channel(r);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(rd.fifo_count), 32'(m_q.size()));
        check({tag, "_empty"}, 32'(rd.fifo_empty), 32'(m_q.size() == 0));
        check({tag, "_afull"}, 32'(rd.fifo_almost_full), 32'((DEPTH - m_q.size()) < AF_FREE));
        check({tag, "_ovr"}, 32'(rd.overrun), 32'(m_ovr));
    endtask

    // All tasks are entered and left at a falling edge.
    task automatic pulse_tick(input logic [15:0] l, input logic [15:0] r);
        next_sample = 1'b1;
        left_in     = l;
        right_in    = r;
        model_tick(l, r);
        @(negedge clk);
        next_sample = 1'b0;
    endtask

    task automatic do_tick(input logic [15:0] l, input logic [15:0] r);
        pulse_tick(l, r);
        repeat (7) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_byte"}, 32'(rd.fifo_rddata), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
        rd.fifo_read = 1'b1;
        @(negedge clk);
        rd.fifo_read = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && m_q.size() > 0; i++) pop_check(tag);
        check_status({tag, "_drained"});
    endtask

    task automatic do_fifo_reset();
        rd.fifo_reset = 1'b1;
        @(negedge clk);
        rd.fifo_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got;
        rd.fifo_reset = 1'b0;
        rd.fifo_read  = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check_status("rst");
        check("rst_rddata", 32'(rd.fifo_rddata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 16-bit stereo with latency checks
        enable = 1'b1; sample_rate = 8'd128; mode_16bit = 1'b1; mode_stereo = 1'b1;
        pulse_tick(16'h1234, 16'hABCD);
        @(negedge clk);
        check("lat_empty_t2", 32'(rd.fifo_empty), 32'h1);
        @(negedge clk);
        check("lat_empty_t3", 32'(rd.fifo_empty), 32'h0);
        check("lat_byte_t3", 32'(rd.fifo_rddata), 32'h34);
        repeat (2) @(negedge clk);
        check("lat_count_t5", 32'(rd.fifo_count), 32'd3);
        @(negedge clk);
        check("lat_count_t6", 32'(rd.fifo_count), 32'd4);
        repeat (2) @(negedge clk);
        check_status("st16");
        drain("st16");

        // Decimation, 8-bit mono
        do_fifo_reset();
        sample_rate = 8'd32; mode_16bit = 1'b0; mode_stereo = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            do_tick(16'h7F00 + 16'(n), 16'h0);
            check("dec_count", 32'(rd.fifo_count), (n >= 8) ? 32'd2 : (n >= 4) ? 32'd1 : 32'd0);
        end
        check("dec_head", 32'(rd.fifo_rddata), 32'h7F);
        drain("dec");
        sample_rate = 8'd0;
        for (int n = 0; n < 4; n++) do_tick(16'($urandom), 16'($urandom));
        check_status("rate0");

        // Admission at the full boundary
        do_fifo_reset();
        sample_rate = 8'd128; mode_16bit = 1'b1; mode_stereo = 1'b1;
        for (int i = 0; i < (DEPTH - 4) / 4; i++) begin
            do_tick(16'($urandom), 16'($urandom));
            check_status("fill");
        end
        mode_stereo = 1'b0;
        do_tick(16'($urandom), 16'($urandom));
        check("full_m2_count", 32'(rd.fifo_count), 32'(DEPTH - 2));
        mode_stereo = 1'b1;
        do_tick(16'($urandom), 16'($urandom));
        check("full_drop_count", 32'(rd.fifo_count), 32'(DEPTH - 2));
        check("full_drop_ovr", 32'(rd.overrun), 32'h1);
        check_status("full_drop");
        pop_check("full_pop");
        pop_check("full_pop");
        do_tick(16'($urandom), 16'($urandom));
        check("full_accept_count", 32'(rd.fifo_count), 32'(DEPTH));
        check_status("full_accept");
        drain("full");

        // Simultaneous write and pop with continuous fifo_read
        rd.fifo_read = 1'b1;
        @(negedge clk);
        check("sim_empty_pop_count", 32'(rd.fifo_count), 32'd0);
        check("sim_empty_pop_data", 32'(rd.fifo_rddata), 32'h0);
        pulse_tick(16'($urandom), 16'($urandom));
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd.fifo_count != '0) begin
                check("sim_byte", 32'(rd.fifo_rddata), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
                if (m_q.size() > 0) void'(m_q.pop_front());
                got++;
            end else begin
                check("sim_idle_data", 32'(rd.fifo_rddata), 32'h0);
            end
            check("sim_count_le1", 32'(rd.fifo_count <= 1), 32'h1);
            @(negedge clk);
        end
        rd.fifo_read = 1'b0;
        check("sim_bytes_seen", 32'(got), 32'd4);
        check_status("sim_end");

        // fifo_reset during PUT_L_HI
        check("frst_ovr_before", 32'(rd.overrun), 32'h1);
        pulse_tick(16'($urandom), 16'($urandom));
        repeat (2) @(negedge clk);
        check("frst_count_before", 32'(rd.fifo_count), 32'd1);
        do_fifo_reset();
        check_status("frst");
        repeat (6) @(negedge clk);
        check_status("frst_idle");
        do_tick(16'h5A3C, 16'hC3A5);
        check("frst_first_byte", 32'(rd.fifo_rddata), 32'h3C);
        drain("frst_next");

        // Asynchronous reset mid-frame
        pulse_tick(16'($urandom), 16'($urandom));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_status("arst");
        check("arst_rddata", 32'(rd.fifo_rddata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_tick(16'($urandom), 16'($urandom));
        check_status("arst_next");
        drain("arst_next");

        // Randomized traffic
        do_fifo_reset();
        for (int it = 0; it < 80; it++) begin
            sample_rate = ($urandom_range(0, 3) == 0) ? 8'd128 : 8'($urandom_range(0, 255));
            mode_16bit  = 1'($urandom_range(0, 1));
            mode_stereo = 1'($urandom_range(0, 1));
            enable      = ($urandom_range(0, 9) != 0);
            do_tick(16'($urandom), 16'($urandom));
            check_status("rnd");
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_check("rnd_pop");
        end
        drain("rnd");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/pcm_capture.md
# pcm_capture

Audio capture path: the recording counterpart of the PCM playback block. It takes signed 16-bit left/right samples from the audio input front end, decimates them with the same 8-bit sample-rate accumulator used for playback, and packs them into a byte stream. The stream goes into an internal capture FIFO, which the register interface drains one byte at a time. It sits between the audio input deserializer and the CPU register file.

## Interface
- FIFO_AW, 10: FIFO address width; depth = 2^FIFO_AW bytes.
- ALMOST_FULL_FREE, 64: `fifo_almost_full` asserts when free space is below this many bytes.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- next_sample  in  1  one-cycle base-rate tick; at least 8 cycles apart.
- left_in  in  16  signed left sample; valid in the `next_sample` cycle.
- right_in  in  16  signed right sample; valid in the `next_sample` cycle.
- enable  in  1  capture enable.
- sample_rate  in  8  accumulator increment; 0 stops capture, 128 captures every tick.
- mode_stereo  in  1  1 = left+right per frame, 0 = left only.
- mode_16bit  in  1  1 = two bytes per channel, 0 = upper byte only.
- fifo_reset  in  1  synchronous clear of FIFO, packer and overrun flag.
- fifo_read  in  1  pops the head byte; ignored when empty.
- fifo_rddata  out  8  head byte (first-word fall-through); 0x00 when empty.
- fifo_empty  out  1  FIFO holds no bytes.
- fifo_almost_full  out  1  free space < ALMOST_FULL_FREE.
- fifo_count  out  FIFO_AW+1  bytes currently stored.
- overrun  out  1  sticky flag: a frame was dropped.

## Operation
- **Accumulator.**
  - On `next_sample` with `enable`=1: `acc <= acc + sample_rate` (mod 256), `acc7_r <= acc[7]`, `left_in`/`right_in` latched into hold registers, `tick_r <= 1`.
  - `capture = tick_r && (acc7_r != acc[7])`.
  - With `enable`=0: `acc` is held at 0 and no capture occurs.
- **Frame config.** `mode_stereo`/`mode_16bit` are latched at capture. Changing the mode mid-frame has no effect on the frame in flight.
- **Frame size F.** 8-bit mono = 1, 8-bit stereo = 2, 16-bit mono = 2, 16-bit stereo = 4.
- **Admission.**
  - On capture in IDLE with free space ≥ F: accept the frame.
  - Otherwise (insufficient space, or packer not in IDLE): drop the whole frame and set `overrun`. A partial frame is never written.
- **Packer FSM**, one byte written per cycle:
  - States: IDLE → PUT_L_LO → PUT_L_HI → PUT_R_LO → PUT_R_HI → IDLE, skipping states that don't apply.
  - 8-bit mode: only the LO states are used, and they write `sample[15:8]`.
  - 16-bit mode: LO writes `[7:0]`, HI writes `[15:8]`.
  - Mono: the R states are skipped.
- **FIFO.**
  - Circular byte buffer; pointers wrap mod 2^FIFO_AW; the count is kept separately so full vs. empty is unambiguous.
  - A simultaneous write and pop in one cycle leaves the count unchanged.
  - Full cannot occur mid-frame because of admission control.
- **overrun.** Set on a drop; cleared only by `fifo_reset` or reset.
- **fifo_reset.** Takes priority over everything in the same cycle:
  - count and pointers = 0, packer → IDLE, `overrun` = 0, `acc` = 0.
  - A pending capture or write in that cycle is discarded.
- **Reset values.** `fifo_empty` = 1; `fifo_rddata` = 0x00; `fifo_count` = 0; `fifo_almost_full` = 0 (unless ALMOST_FULL_FREE > depth); `overrun` = 0; FSM IDLE; `acc` = 0. Reset asserted mid-frame abandons the frame.

## Timing
- Tick in cycle T → capture decision in T+1 → first byte written at the edge ending T+2.
- `fifo_empty` falls and `fifo_rddata` is valid in T+3. The last byte of a 4-byte frame is written at the edge ending T+5.
- Pop: `fifo_read` in cycle C → the next byte is presented on `fifo_rddata` in C+1; the count decrements at the same edge.
- `fifo_count`, `fifo_empty` and `fifo_almost_full` are registered and reflect the edge-updated count.

## Test plan
- **16-bit stereo.** `sample_rate`=128, `mode_16bit`=1, `mode_stereo`=1, one tick with L=0x1234, R=0xABCD → FIFO bytes 34,12,CD,AB; `fifo_count`=4; `overrun`=0.
- **Decimation, 8-bit mono.** `sample_rate`=32, 8 ticks with L=0x7F00+n → exactly 2 bytes (0x7F,0x7F), captured at ticks 4 and 8; `sample_rate`=0 → no bytes.
- **Admission at the full boundary.** Fill to depth−2, then a 16-bit stereo frame → dropped, count unchanged, `overrun`=1. Pop 2, next frame → accepted, count = depth.
- **Simultaneous write and pop.** Continuous `fifo_read` during a 4-byte frame → bytes come out in order, count never exceeds 1, empty pops ignored with `fifo_rddata`=0x00.
- **fifo_reset mid-frame.** Assert in PUT_L_HI → count 0, FSM IDLE, `overrun` cleared; the next capture starts with the L_LO byte.
- **Async reset.** Assert `rst_n` low mid-frame, outside a clock edge → outputs go to reset values immediately; after release the first frame is complete and correct.
